// File: rtl/udp_pkg.sv
// Shared definitions for the UDP transmit packetizer: FSM encoding and payload limits.
package udp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_SEND  = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  localparam int MAX_UDP_WORDS = 368;
  localparam int BYTE_SHIFT    = 2;
  localparam int WORDS_W       = $clog2(MAX_UDP_WORDS + 1);

endpackage

// File: rtl/udp_tx_fifo.sv
// Synchronous 32-bit FIFO with registered read data and occupancy count.
module udp_tx_fifo #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  output logic [31:0]   rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [31:0]   mem [0:(1 << AW) - 1];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full  = (count == DEPTH);
  assign empty = (count == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/udp_tx_packetizer.sv
// Buffers a 32-bit word stream and cuts it into UDP payloads for the transmitter.
//   state | meaning
//   IDLE  | waiting for a full payload, flush or timeout
//   LOAD  | latch payload length from FIFO occupancy
//   START | one-cycle tx_start_en pulse
//   SEND  | pop one word per tx_request until the payload is exhausted
//   WAIT  | all words handed over, waiting for tx_done
module udp_tx_packetizer
  import udp_pkg::*;
#(
  parameter int PKT_WORDS = 256,
  parameter int FIFO_AW   = 10,
  parameter int TIMEOUT   = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic        flush,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  output logic [31:0] tx_data,
  input  logic        tx_request,
  input  logic        tx_done,
  output logic        busy,
  output logic [15:0] pkt_cnt
);

  localparam logic [FIFO_AW:0] PKT_CNT = (FIFO_AW + 1)'(PKT_WORDS);
  localparam logic [31:0]      TO_LOAD = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  state_t               state;
  state_t               state_nxt;
  logic [FIFO_AW:0]     count;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 launch;
  logic                 flush_pend;
  logic                 to_run;
  logic                 to_hit;
  logic [31:0]          to_cnt;
  logic [WORDS_W-1:0]   words_left;
  logic [WORDS_W-1:0]   load_words;

  udp_tx_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (tx_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign in_ready   = !full;
  assign push       = in_valid && in_ready;
  assign pop        = (state == ST_SEND) && tx_request && (words_left != '0);
  assign busy       = (state != ST_IDLE);
  assign launch     = (count >= PKT_CNT) || (flush_pend && !empty);
  assign load_words = (count >= PKT_CNT) ? WORDS_W'(PKT_WORDS) : WORDS_W'(count);

  // Timer only arms for a partial payload sitting idle; a push always re-arms it.
  assign to_run = (TIMEOUT > 0) && (state == ST_IDLE) && !empty && (count < PKT_CNT);
  assign to_hit = to_run && !push && (to_cnt == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (launch) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_START;
      ST_START: state_nxt = ST_SEND;
      ST_SEND: begin
        if (tx_done)                 state_nxt = ST_IDLE;
        else if (words_left == '0)   state_nxt = ST_WAIT;
      end
      ST_WAIT:  if (tx_done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      tx_start_en <= 1'b0;
      tx_byte_num <= '0;
      words_left  <= '0;
      pkt_cnt     <= '0;
      flush_pend  <= 1'b0;
      to_cnt      <= TO_LOAD;
    end else begin
      state       <= state_nxt;
      tx_start_en <= (state == ST_LOAD);

      if (state == ST_LOAD) begin
        words_left  <= load_words;
        tx_byte_num <= 16'(load_words) << BYTE_SHIFT;
      end else if (pop) begin
        words_left  <= words_left - 1'b1;
      end

      if ((state == ST_SEND || state == ST_WAIT) && tx_done) pkt_cnt <= pkt_cnt + 1'b1;

      if (flush || to_hit)                  flush_pend <= 1'b1;
      else if (state == ST_LOAD || empty)   flush_pend <= 1'b0;

      if (push || state != ST_IDLE)   to_cnt <= TO_LOAD;
      else if (to_run && to_cnt != '0) to_cnt <= to_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Self-checking bench: two packetizer configurations share stimulus, one is observed per test.
module tb_udp_tx_packetizer;

  localparam int PKT_A = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        flush = 1'b0;
  logic        tx_request = 1'b0;
  logic        tx_done = 1'b0;

  logic        a_ready, a_start, a_busy, b_ready, b_start, b_busy;
  logic [15:0] a_bytes, a_pkt, b_bytes, b_pkt;
  logic [31:0] a_data, b_data;

  logic        o_ready, o_start, o_busy;
  logic [15:0] o_bytes, o_pkt;
  logic [31:0] o_data;

  int          checks = 0;
  int          failures = 0;
  bit          sel = 1'b0;
  int          frames = 0;
  logic [31:0] model_q[$];

  always #5 clk = ~clk;

  udp_tx_packetizer #(.PKT_WORDS(PKT_A), .FIFO_AW(4), .TIMEOUT(50)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(a_ready),
    .flush(flush), .tx_start_en(a_start), .tx_byte_num(a_bytes), .tx_data(a_data),
    .tx_request(tx_request), .tx_done(tx_done), .busy(a_busy), .pkt_cnt(a_pkt)
  );

  udp_tx_packetizer #(.PKT_WORDS(8), .FIFO_AW(3), .TIMEOUT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(b_ready),
    .flush(flush), .tx_start_en(b_start), .tx_byte_num(b_bytes), .tx_data(b_data),
    .tx_request(tx_request), .tx_done(tx_done), .busy(b_busy), .pkt_cnt(b_pkt)
  );

  assign o_ready = sel ? b_ready : a_ready;
  assign o_start = sel ? b_start : a_start;
  assign o_busy  = sel ? b_busy  : a_busy;
  assign o_bytes = sel ? b_bytes : a_bytes;
  assign o_pkt   = sel ? b_pkt   : a_pkt;
  assign o_data  = sel ? b_data  : a_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit s);
    sel = s;
    in_valid = 1'b0; flush = 1'b0; tx_request = 1'b0; tx_done = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_q.delete();
    frames = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (o_ready !== 1'b1 || o_start !== 1'b0 || o_bytes !== 16'd0 || o_data !== 32'd0 ||
        o_busy !== 1'b0 || o_pkt !== 16'd0) begin
      failures++;
      $display("FAIL %s got ready=%b start=%b bytes=%0d data=%h busy=%b pkt=%0d exp 1 0 0 0 0 0",
               tag, o_ready, o_start, o_bytes, o_data, o_busy, o_pkt);
    end
  endtask

  task automatic push_word(input logic [31:0] d);
    bit rdy;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 400; i++) begin
      rdy = o_ready;
      tick();
      if (rdy) begin
        model_q.push_back(d);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    checks++; failures++;
    $display("FAIL push_timeout word=%h never accepted", d);
  endtask

  task automatic wait_start(input int budget, output int cyc, output bit ok);
    ok = 1'b0;
    cyc = 0;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if (o_start) begin
        ok = 1'b1;
        cyc = c;
        return;
      end
    end
  endtask

  task automatic check_start(input string tag, input bit ok, input int exp_bytes);
    checks++;
    if (!ok || o_bytes !== 16'(exp_bytes)) begin
      failures++;
      $display("FAIL %s start_seen=%b bytes=%0d exp start=1 bytes=%0d", tag, ok, o_bytes, exp_bytes);
    end
  endtask

  task automatic req_one(input string tag, input int idx, input bit take, inout logic [31:0] last);
    logic [31:0] exp;
    tx_request = 1'b1;
    tick();
    tx_request = 1'b0;
    exp = last;
    if (take && model_q.size() > 0) exp = model_q.pop_front();
    checks++;
    if (o_data !== exp) begin
      failures++;
      $display("FAIL %s data[%0d] got=%h exp=%h", tag, idx, o_data, exp);
    end
    last = exp;
    tick();
  endtask

  // Called right after tx_start_en is seen; issues nreq requests for an nw-word payload.
  task automatic drain(input int nw, input int nreq, input string tag);
    logic [31:0] last = '0;
    bit extra = 1'b0;
    tick();
    for (int i = 0; i < nreq; i++) begin
      req_one(tag, i, i < nw, last);
      if (o_start) extra = 1'b1;
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    frames++;
    checks++;
    if (extra || o_busy !== 1'b0 || o_pkt !== 16'(frames)) begin
      failures++;
      $display("FAIL %s_end extra_start=%b busy=%b pkt=%0d exp 0 0 %0d", tag, extra, o_busy, o_pkt, frames);
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    check_reset_vals("reset_a");
    sel = 1'b1;
    check_reset_vals("reset_b");
  endtask

  task automatic test_full_packet();
    int cyc; bit ok;
    do_reset(1'b0);
    for (int i = 1; i <= 4; i++) push_word(32'(i));
    wait_start(20, cyc, ok);
    check_start("full_start", ok, 16);
    drain(4, 4, "full");
  endtask

  task automatic test_partial_flush();
    int cyc; bit ok;
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) push_word($urandom);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_start(20, cyc, ok);
    check_start("partial_start", ok, 12);
    drain(3, 4, "partial");
  endtask

  task automatic test_backpressure();
    int cyc; bit ok; bit held = 1'b1;
    logic [31:0] w9 = $urandom;
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) push_word($urandom);
    checks++;
    if (o_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_full in_ready=%b exp 0", o_ready);
    end
    wait_start(20, cyc, ok);
    check_start("bp_start1", ok, 32);
    in_valid = 1'b1;
    in_data  = w9;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (o_ready !== 1'b0) held = 1'b0;
    end
    checks++;
    if (!held) begin
      failures++;
      $display("FAIL bp_hold in_ready rose before any pop, exp 0");
    end
    fork
      push_word(w9);
      begin
        #0;
        drain(8, 8, "bp1");
      end
    join
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_start(20, cyc, ok);
    check_start("bp_start2", ok, 4);
    drain(1, 1, "bp2");
    checks++;
    if (model_q.size() != 0) begin
      failures++;
      $display("FAIL bp_leftover words=%0d exp 0", model_q.size());
    end
  endtask

  task automatic test_timeout();
    int cyc; bit ok; bit early = 1'b0;
    do_reset(1'b0);
    push_word($urandom);
    push_word($urandom);
    wait_start(80, cyc, ok);
    checks++;
    if (!ok || cyc < 48 || cyc > 56) begin
      failures++;
      $display("FAIL timeout_delay got=%0d seen=%b exp about 52", cyc, ok);
    end
    check_start("timeout_start", ok, 8);
    drain(2, 2, "timeout");
    push_word($urandom);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_start) early = 1'b1;
    end
    push_word($urandom);
    wait_start(80, cyc, ok);
    checks++;
    if (early || !ok || cyc < 48 || cyc > 56) begin
      failures++;
      $display("FAIL timeout_restart got=%0d early=%b seen=%b exp about 52", cyc, early, ok);
    end
    check_start("restart_start", ok, 8);
    drain(2, 2, "restart");
  endtask

  task automatic test_reset_mid_send();
    int cyc; bit ok;
    logic [31:0] last = '0;
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) push_word($urandom);
    wait_start(20, cyc, ok);
    check_start("rst_start", ok, 16);
    tick();
    req_one("rst_pre", 0, 1'b1, last);
    req_one("rst_pre", 1, 1'b1, last);
    rst_n = 1'b0;
    tick();
    check_reset_vals("rst_mid");
    rst_n = 1'b1;
    model_q.delete();
    frames = 0;
    for (int i = 0; i < 4; i++) push_word($urandom);
    wait_start(20, cyc, ok);
    check_start("rst_fresh_start", ok, 16);
    drain(4, 4, "rst_fresh");
  endtask

  task automatic test_spurious();
    int cyc; bit ok; bit early = 1'b0;
    do_reset(1'b1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    checks++;
    if (o_busy !== 1'b0 || o_pkt !== 16'd0) begin
      failures++;
      $display("FAIL spurious_done busy=%b pkt=%0d exp 0 0", o_busy, o_pkt);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tick();
    push_word($urandom);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_start) early = 1'b1;
    end
    checks++;
    if (early) begin
      failures++;
      $display("FAIL empty_flush_stale start=1 exp 0");
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_start(20, cyc, ok);
    check_start("empty_flush_after", ok, 4);
    drain(1, 1, "empty_flush");
  endtask

  task automatic test_random_stream();
    int n = $urandom_range(10, 30);
    int sent = 0;
    bit prod_done = 1'b0;
    do_reset(1'b0);
    fork
      begin
        for (int i = 0; i < n; i++) begin
          push_word($urandom);
          repeat ($urandom_range(0, 6)) tick();
        end
        prod_done = 1'b1;
      end
      begin
        int nw;
        bit got;
        forever begin
          got = 1'b0;
          for (int c = 0; c < 300; c++) begin
            if (prod_done && model_q.size() == 0) break;
            tick();
            if (o_start) begin
              got = 1'b1;
              break;
            end
          end
          if (!got) begin
            if (!(prod_done && model_q.size() == 0)) begin
              checks++; failures++;
              $display("FAIL rand_stall queued=%0d no start seen", model_q.size());
            end
            break;
          end
          nw = int'(o_bytes) / 4;
          checks++;
          if (o_bytes[1:0] != 2'b00 || nw < 1 || nw > PKT_A || nw > model_q.size()) begin
            failures++;
            $display("FAIL rand_len bytes=%0d queued=%0d exp 4..%0d", o_bytes, model_q.size(), PKT_A * 4);
            if (nw > model_q.size()) nw = model_q.size();
          end
          sent += nw;
          drain(nw, nw, "rand");
        end
      end
    join
    checks++;
    if (sent != n || model_q.size() != 0) begin
      failures++;
      $display("FAIL rand_total sent=%0d exp %0d leftover=%0d", sent, n, model_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_packet();
    test_partial_flush();
    test_backpressure();
    test_timeout();
    test_reset_mid_send();
    test_spurious();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
